// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the MMIO load path.
// First-word-fall-through read; sticky overflow on a dropped byte.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              rd_en,
  input  logic              clr_overflow,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic              r_rx_valid_q;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_pop_req;
  logic w_push_ok;
  logic w_drop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LP_DEPTH);
  // Held rx_valid yields a single push on its rising edge
  assign w_push_req = rx_valid & ~r_rx_valid_q;
  assign w_pop_req  = rd_en & ~w_empty;
  assign w_push_ok  = w_push_req & (~w_full | w_pop_req);
  assign w_drop     = w_push_req & ~w_push_ok;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ovf        <= 1'b0;
      r_rx_valid_q <= 1'b0;
    end else begin
      r_rx_valid_q <= rx_valid;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_req) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push_ok, w_pop_req})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clr_overflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign rd_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_ovf;

endmodule
